// File: rtl/score_keeper_fsm.sv
// score_keeper_fsm: pong goal detection, score counters, serve hold-off and match end.
// One goal per PLAY visit; the ball must leave the goal zone before it can score again.
module score_keeper_fsm #(
    parameter int X_MAX       = 639,
    parameter int BALL_HALF   = 5,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 60
) (
    input  logic               clk,
    input  logic               reset_score_n,
    input  logic               frame_tick,
    input  logic [9:0]         ball_x_pos,
    input  logic               new_game,
    output logic               reset_n,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic               goal_pulse,
    output logic               game_over,
    output logic               winner
);
    typedef enum logic [1:0] {PLAY, SERVE, OVER} state_t;

    state_t             state;
    logic [7:0]         serve_cnt;
    logic               armed;
    logic               left_hit, right_hit, score_now, left_win, right_win;
    logic [SCORE_W-1:0] left_next, right_next;

    always_comb begin
        left_hit  = ball_x_pos <= 10'(BALL_HALF);
        right_hit = {1'b0, ball_x_pos} + 11'(BALL_HALF) >= 11'(X_MAX);
        score_now = state == PLAY && armed && (left_hit || right_hit) && !new_game;
        left_next  = left_score + 1'b1;
        right_next = right_score + 1'b1;
        left_win   = left_next == SCORE_W'(WIN_SCORE);
        right_win  = right_next == SCORE_W'(WIN_SCORE);
    end

    always_ff @(posedge clk or negedge reset_score_n) begin
        if (!reset_score_n) begin
            state       <= SERVE;
            serve_cnt   <= 8'(SERVE_TICKS);
            left_score  <= '0;
            right_score <= '0;
            reset_n     <= 1'b0;
            goal_pulse  <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            armed       <= 1'b1;
        end else begin
            goal_pulse <= 1'b0;
            // re-arm only once the ball has been seen outside both goal zones
            armed      <= score_now ? 1'b0 : (armed || !(left_hit || right_hit));
            if (new_game) begin
                state       <= SERVE;
                serve_cnt   <= 8'(SERVE_TICKS);
                left_score  <= '0;
                right_score <= '0;
                reset_n     <= 1'b0;
                game_over   <= 1'b0;
                winner      <= 1'b0;
            end else if (score_now) begin
                goal_pulse <= 1'b1;
                reset_n    <= 1'b0;
                serve_cnt  <= 8'(SERVE_TICKS);
                if (left_hit) begin
                    left_score <= left_next;
                    winner     <= 1'b0;
                    game_over  <= left_win;
                    state      <= left_win ? OVER : SERVE;
                end else begin
                    right_score <= right_next;
                    winner      <= 1'b1;
                    game_over   <= right_win;
                    state       <= right_win ? OVER : SERVE;
                end
            end else if (state == SERVE && frame_tick) begin
                if (serve_cnt == 8'd1) begin
                    state   <= PLAY;
                    reset_n <= 1'b1;
                end else begin
                    serve_cnt <= serve_cnt - 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_score_keeper_fsm.sv
// tb_score_keeper_fsm: directed stimulus with a behavioural score model checked every cycle.
module tb_score_keeper_fsm;
    localparam int ST = 60;
    localparam int CENTRE = 320;

    logic       clk = 1'b0;
    logic       reset_score_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] ball_x_pos = 10'(CENTRE);
    logic       new_game = 1'b0;
    logic       reset_n, goal_pulse, game_over, winner;
    logic [3:0] left_score, right_score;

    int total = 0;
    int bad = 0;

    score_keeper_fsm dut (
        .clk(clk), .reset_score_n(reset_score_n), .frame_tick(frame_tick),
        .ball_x_pos(ball_x_pos), .new_game(new_game), .reset_n(reset_n),
        .left_score(left_score), .right_score(right_score),
        .goal_pulse(goal_pulse), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // model: match phase as flags, ticks still owed before play, scores as ints
    bit m_play, m_over, m_pulse, m_win, m_armed;
    int m_left, m_right, m_ticks_left;

    always @(posedge clk or negedge reset_score_n) begin
        bit lh, rh;
        if (!reset_score_n) begin
            m_play = 0; m_over = 0; m_pulse = 0; m_win = 0; m_armed = 1;
            m_left = 0; m_right = 0; m_ticks_left = ST;
        end else begin
            lh = int'(ball_x_pos) <= 5;
            rh = int'(ball_x_pos) + 5 >= 639;
            m_pulse = 0;
            if (new_game) begin
                m_left = 0; m_right = 0; m_over = 0; m_play = 0; m_ticks_left = ST;
                if (!(lh || rh)) m_armed = 1;
            end else if (m_play && m_armed && (lh || rh)) begin
                m_pulse = 1; m_play = 0; m_armed = 0; m_ticks_left = ST;
                if (lh) m_left++; else m_right++;
                m_win = !lh;
                m_over = (m_left == 9) || (m_right == 9);
            end else begin
                if (!(lh || rh)) m_armed = 1;
                if (!m_play && !m_over && frame_tick) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) m_play = 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("reset_n", int'(reset_n), int'(m_play));
        check("left_score", int'(left_score), m_left);
        check("right_score", int'(right_score), m_right);
        check("goal_pulse", int'(goal_pulse), int'(m_pulse));
        check("game_over", int'(game_over), int'(m_over));
        if (m_over) check("winner", int'(winner), int'(m_win));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(2);
    endtask

    task automatic serve();
        repeat (ST) tick();
    endtask

    task automatic goal(input int x);
        ball_x_pos = 10'(x);
        cyc(1);
        ball_x_pos = 10'(CENTRE);
        cyc(1);
    endtask

    initial begin
        cyc(3);
        check("rst reset_n", int'(reset_n), 0);
        check("rst scores", int'({left_score, right_score}), 0);
        check("rst over", int'(game_over), 0);
        reset_score_n = 1'b1;
        cyc(2);
        repeat (ST - 1) tick();
        check("59 ticks still serving", int'(reset_n), 0);
        tick();
        check("60th tick starts play", int'(reset_n), 1);
        check("0/0 at play", int'({left_score, right_score}), 0);

        ball_x_pos = 10'd5;
        cyc(1);
        check("left goal x=5", int'(left_score), 1);
        check("goal pulse", int'(goal_pulse), 1);
        cyc(1);
        check("pulse one cycle", int'(goal_pulse), 0);
        serve();
        cyc(5);
        check("held x=5 no rescore", int'(left_score), 1);
        check("held x=5 in play", int'(reset_n), 1);
        ball_x_pos = 10'(CENTRE);
        cyc(2);

        goal(634);
        check("right goal x=634", int'(right_score), 1);
        serve();
        goal(700);
        check("right goal x=700", int'(right_score), 2);
        serve();

        repeat (8) begin
            goal(5);
            if (!game_over) serve();
        end
        check("left reaches 9", int'(left_score), 9);
        check("over", int'(game_over), 1);
        check("winner left", int'(winner), 0);
        check("over holds reset_n", int'(reset_n), 0);
        goal(5);
        goal(700);
        repeat (70) tick();
        check("frozen left", int'(left_score), 9);
        check("frozen right", int'(right_score), 2);

        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
        check("new_game scores", int'({left_score, right_score}), 0);
        check("new_game over", int'(game_over), 0);
        serve();
        check("play after new_game", int'(reset_n), 1);
        new_game = 1'b1;
        ball_x_pos = 10'd5;
        cyc(1);
        new_game = 1'b0;
        ball_x_pos = 10'(CENTRE);
        cyc(1);
        check("new_game beats goal", int'(left_score), 0);
        serve();

        goal(5); serve();
        goal(5); serve();
        goal(639); serve();
        goal(5); serve();
        goal(700);
        repeat (10) tick();
        check("3/2 before reset", int'({left_score, right_score}), 8'h32);
        #2 reset_score_n = 1'b0;
        #1;
        check("async reset scores", int'({left_score, right_score}), 0);
        check("async reset reset_n", int'(reset_n), 0);
        check("async reset over/pulse/winner", int'({game_over, goal_pulse, winner}), 0);
        cyc(2);
        reset_score_n = 1'b1;
        cyc(1);
        repeat (ST - 1) tick();
        check("serve after reset", int'(reset_n), 0);
        tick();
        check("play after reset", int'(reset_n), 1);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
